keypad_entry: RTL and testbench

Scans a 4x4 matrix keypad, debounces presses and releases, and turns key events into the 4-bit password nibble plus one-cycle enter strobe consumed by the room lock controller. It is the transmitting end of the password_input/enter interface. Its outputs connect directly to the lock controller's password_input and enter inputs.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/key_debounce.sv | 36 +++
 rtl/keypad_entry.sv | 172 +++++++++++++++++
 tb/tb_keypad_entry.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key codes for the keypad entry block.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam logic [3:0] KEY_CLEAR  = 4'hE;
   localparam logic [3:0] KEY_ENTER  = 4'hF;
   localparam logic [3:0] NO_KEY_ROW = 4'hF;

   // Several rows low on one column resolve to the lowest-numbered row.
   function automatic logic [1:0] lowestLowRow(input logic [3:0] rowBits);
      logic [1:0] idx;
      if (!rowBits[0])      idx = 2'd0;
      else if (!rowBits[1]) idx = 2'd1;
      else if (!rowBits[2]) idx = 2'd2;
      else                  idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Consecutive-match counter; done pulses on the DEBOUNCE_CYCLES-th matching cycle.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   input  logic match,
   output logic done
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] count_q, count_d;

   assign done = enable && match && (count_q == CW'(DEBOUNCE_CYCLES - 1));

   // Dropping enable doubles as restart, so each new debounce window starts from zero.
   always_comb begin
      count_d = count_q;
      if (!enable || !match || done) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner producing a password nibble and enter strobe.
// Optional ENTRY_TIMEOUT_EN discards a pending digit after TIMEOUT_CYCLES idle scan cycles.
module keypad_entry #(
   parameter int SCAN_HOLD       = 4,
   parameter int DEBOUNCE_CYCLES = 16
`ifdef ENTRY_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES  = 1000000
`endif
) (
   input  logic       clock,
   input  logic       clear,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] password_input,
   output logic       enter,
   output logic       key_valid,
   output logic       key_pressed
);

   import keypad_pkg::*;

   localparam int HW = $clog2(SCAN_HOLD + 1);

   state_t        state_q, state_d;
   logic [1:0]    colIdx_q, colIdx_d;
   logic [1:0]    rowIdx_q, rowIdx_d;
   logic [3:0]    rowPat_q, rowPat_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [3:0]    pwd_q, pwd_d;
   logic          keyValid_q, keyValid_d;
   logic          enter_q, enter_d;

   logic          dbEnable, dbMatch, dbDone;
   logic          accept, timeoutHit;
   logic [3:0]    code;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clock  (clock),
      .clear  (clear),
      .enable (dbEnable),
      .match  (dbMatch),
      .done   (dbDone)
   );

   assign code = {rowIdx_q, colIdx_q};

   always_comb begin
      state_d    = state_q;
      colIdx_d   = colIdx_q;
      rowIdx_d   = rowIdx_q;
      rowPat_d   = rowPat_q;
      hold_d     = hold_q;
      pwd_d      = pwd_q;
      keyValid_d = keyValid_q;
      enter_d    = 1'b0;
      dbEnable   = 1'b0;
      dbMatch    = 1'b0;
      accept     = 1'b0;

      case (state_q)
         SCAN: begin
            if (hold_q == HW'(SCAN_HOLD - 1)) begin
               hold_d = '0;
               if (row != NO_KEY_ROW) begin
                  rowIdx_d = lowestLowRow(row);
                  rowPat_d = row;
                  state_d  = DEBOUNCE;
               end else begin
                  colIdx_d = colIdx_q + 2'd1;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            dbEnable = 1'b1;
            dbMatch  = (row == rowPat_q);
            if (!dbMatch) begin
               colIdx_d = colIdx_q + 2'd1;
               state_d  = SCAN;
            end else if (dbDone) begin
               accept  = 1'b1;
               state_d = HELD;
            end
         end
         HELD: begin
            if (row == NO_KEY_ROW) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            dbEnable = 1'b1;
            dbMatch  = (row == NO_KEY_ROW);
            if (dbDone) begin
               colIdx_d = 2'd0;
               state_d  = SCAN;
            end
         end
         default: state_d = SCAN;
      endcase

      // The key action fires only on the debounce-accept cycle, so a held key never repeats.
      if (accept) begin
         if (code == KEY_CLEAR) begin
            pwd_d      = 4'h0;
            keyValid_d = 1'b0;
         end else if (code == KEY_ENTER) begin
            if (keyValid_q) begin
               enter_d    = 1'b1;
               keyValid_d = 1'b0;
            end
         end else begin
            pwd_d      = code;
            keyValid_d = 1'b1;
         end
      end

      if (timeoutHit) begin
         pwd_d      = 4'h0;
         keyValid_d = 1'b0;
      end
   end

`ifdef ENTRY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_q;

   assign timeoutHit = keyValid_q && (state_q == SCAN) && (idle_q == TW'(TIMEOUT_CYCLES - 1));

   // Idle time accumulates only while a digit is pending and the scanner sees no key.
   always_ff @(posedge clock) begin
      if (clear || accept || timeoutHit) begin
         idle_q <= '0;
      end else if (keyValid_q && (state_q == SCAN)) begin
         idle_q <= idle_q + 1'b1;
      end
   end
`else
   assign timeoutHit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q    <= SCAN;
         colIdx_q   <= 2'd0;
         rowIdx_q   <= 2'd0;
         rowPat_q   <= NO_KEY_ROW;
         hold_q     <= '0;
         pwd_q      <= 4'h0;
         keyValid_q <= 1'b0;
         enter_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         colIdx_q   <= colIdx_d;
         rowIdx_q   <= rowIdx_d;
         rowPat_q   <= rowPat_d;
         hold_q     <= hold_d;
         pwd_q      <= pwd_d;
         keyValid_q <= keyValid_d;
         enter_q    <= enter_d;
      end
   end

   assign col            = ~(4'b0001 << colIdx_q);
   assign password_input = pwd_q;
   assign enter          = enter_q;
   assign key_valid      = keyValid_q;
   assign key_pressed    = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with SCAN_HOLD=2, DEBOUNCE_CYCLES=4 and a modelled key matrix.
module tb_keypad_entry;

   logic       clock = 1'b0;
   logic       clear;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] password_input;
   logic       enter;
   logic       key_valid;
   logic       key_pressed;

   logic [3:0] rowMask = 4'hF;
   logic [1:0] keyCol  = 2'd0;

   int         testsRun    = 0;
   int         testsFailed = 0;
   int         enterCount  = 0;
   int         pressCount  = 0;
   logic [3:0] enterPwd    = 4'h0;
   logic       enterKv     = 1'b0;
   logic       prevPressed = 1'b0;
   int         pressBase;
   int         enterBase;

   always #5 clock = ~clock;

   // A pressed switch connects its row to its column; rows read high unless that column is driven low.
   assign row = (col[keyCol] == 1'b0) ? rowMask : 4'hF;

`ifdef ENTRY_TIMEOUT_EN
   keypad_entry #(.SCAN_HOLD(2), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
`else
   keypad_entry #(.SCAN_HOLD(2), .DEBOUNCE_CYCLES(4)) dut (
`endif
      .clock          (clock),
      .clear          (clear),
      .row            (row),
      .col            (col),
      .password_input (password_input),
      .enter          (enter),
      .key_valid      (key_valid),
      .key_pressed    (key_pressed)
   );

   always @(negedge clock) begin
      if (!clear) begin
         if (enter === 1'b1) begin
            enterCount++;
            enterPwd = password_input;
            enterKv  = key_valid;
         end
         if (key_pressed === 1'b1 && !prevPressed) begin
            pressCount++;
         end
      end
      prevPressed = (key_pressed === 1'b1);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input logic [1:0] c);
      rowMask = mask;
      keyCol  = c;
   endtask

   task automatic waitPressed(input logic level, input string tag);
      int n = 0;
      while (key_pressed !== level && n < 200) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, {7'd0, key_pressed}, {7'd0, level});
   endtask

   task automatic pressRelease(input logic [1:0] r, input logic [1:0] c, input string tag);
      applyStimulus(~(4'b0001 << r), c);
      waitPressed(1'b1, {tag, "_down"});
      applyStimulus(4'hF, 2'd0);
      waitPressed(1'b0, {tag, "_up"});
      tick(2);
   endtask

   initial begin
      clear = 1'b1;
      tick(3);
      checkOutput("reset_col", {4'd0, col}, 8'h0E);
      checkOutput("reset_pwd", {4'd0, password_input}, 8'h00);
      checkOutput("reset_enter", {7'd0, enter}, 8'h00);
      checkOutput("reset_kv", {7'd0, key_valid}, 8'h00);
      checkOutput("reset_kp", {7'd0, key_pressed}, 8'h00);

      // Press row0/col0 and clear two cycles into its debounce window.
      clear = 1'b0;
      applyStimulus(4'b1110, 2'd0);
      tick(3);
      clear = 1'b1;
      applyStimulus(4'hF, 2'd0);
      tick(1);
      checkOutput("middeb_col", {4'd0, col}, 8'h0E);
      checkOutput("middeb_pwd", {4'd0, password_input}, 8'h00);
      checkOutput("middeb_enter", {7'd0, enter}, 8'h00);
      checkOutput("middeb_kv", {7'd0, key_valid}, 8'h00);
      checkOutput("middeb_kp", {7'd0, key_pressed}, 8'h00);
      clear = 1'b0;
      tick(20);
      checkOutput("middeb_noaccept_kv", {7'd0, key_valid}, 8'h00);

      pressRelease(2'd2, 2'd2, "digitA");
      checkOutput("digitA_pwd", {4'd0, password_input}, 8'h0A);
      checkOutput("digitA_kv", {7'd0, key_valid}, 8'h01);
      checkOutput("digitA_noenter", enterCount[7:0], 8'd0);
      pressRelease(2'd3, 2'd3, "submitA");
      checkOutput("submitA_count", enterCount[7:0], 8'd1);
      checkOutput("submitA_enterpwd", {4'd0, enterPwd}, 8'h0A);
      checkOutput("submitA_enterkv", {7'd0, enterKv}, 8'h00);
      checkOutput("submitA_pwd", {4'd0, password_input}, 8'h0A);
      checkOutput("submitA_kv", {7'd0, key_valid}, 8'h00);

      // Row1 on col2 chatters every cycle, never stable for four consecutive cycles.
      pressBase = pressCount;
      for (int i = 0; i < 24; i++) begin
         applyStimulus((i % 2 == 0) ? 4'b1101 : 4'hF, 2'd2);
         tick(1);
      end
      checkOutput("bounce_nopress", 8'(pressCount - pressBase), 8'd0);
      checkOutput("bounce_kv", {7'd0, key_valid}, 8'h00);
      applyStimulus(4'b1101, 2'd2);
      waitPressed(1'b1, "bounce_down");
      checkOutput("bounce_pwd", {4'd0, password_input}, 8'h06);
      tick(100);
      checkOutput("hold_onepress", 8'(pressCount - pressBase), 8'd1);
      checkOutput("hold_kp", {7'd0, key_pressed}, 8'h01);
      checkOutput("hold_kv", {7'd0, key_valid}, 8'h01);
      applyStimulus(4'hF, 2'd0);
      waitPressed(1'b0, "bounce_up");
      tick(2);

      enterBase = enterCount;
      pressRelease(2'd3, 2'd2, "clr1");
      checkOutput("clr1_pwd", {4'd0, password_input}, 8'h00);
      checkOutput("clr1_kv", {7'd0, key_valid}, 8'h00);
      pressRelease(2'd3, 2'd3, "emptyenter");
      checkOutput("emptyenter_none", 8'(enterCount - enterBase), 8'd0);
      pressRelease(2'd0, 2'd3, "digit3");
      checkOutput("digit3_pwd", {4'd0, password_input}, 8'h03);
      pressRelease(2'd3, 2'd2, "clr2");
      pressRelease(2'd3, 2'd3, "enterAfterClr");
      checkOutput("clr2_pwd", {4'd0, password_input}, 8'h00);
      checkOutput("clr2_noenter", 8'(enterCount - enterBase), 8'd0);

      pressRelease(2'd0, 2'd1, "digit1");
      pressRelease(2'd1, 2'd1, "digit5");
      checkOutput("overwrite_pwd", {4'd0, password_input}, 8'h05);
      pressRelease(2'd3, 2'd3, "submit5");
      checkOutput("submit5_count", 8'(enterCount - enterBase), 8'd1);
      checkOutput("submit5_enterpwd", {4'd0, enterPwd}, 8'h05);

      applyStimulus(4'b1001, 2'd0);
      waitPressed(1'b1, "multirow_down");
      applyStimulus(4'hF, 2'd0);
      waitPressed(1'b0, "multirow_up");
      tick(2);
      checkOutput("multirow_pwd", {4'd0, password_input}, 8'h04);
      checkOutput("multirow_kv", {7'd0, key_valid}, 8'h01);

      enterBase = enterCount;
      pressRelease(2'd1, 2'd3, "digit7");
      checkOutput("digit7_pwd", {4'd0, password_input}, 8'h07);
      tick(80);
`ifdef ENTRY_TIMEOUT_EN
      checkOutput("timeout_kv", {7'd0, key_valid}, 8'h00);
      checkOutput("timeout_pwd", {4'd0, password_input}, 8'h00);
      pressRelease(2'd3, 2'd3, "timeoutEnter");
      checkOutput("timeout_noenter", 8'(enterCount - enterBase), 8'd0);
`else
      checkOutput("pending_kv", {7'd0, key_valid}, 8'h01);
      checkOutput("pending_pwd", {4'd0, password_input}, 8'h07);
      pressRelease(2'd3, 2'd3, "pendingEnter");
      checkOutput("pending_enter", 8'(enterCount - enterBase), 8'd1);
      checkOutput("pending_enterpwd", {4'd0, enterPwd}, 8'h07);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
